// File: rtl/serial_cla_addsub.sv
// ============================================================================
// Module  : serial_cla_addsub
// Purpose : Nibble-serial WIDTH-bit adder/subtractor with 4-bit lookahead
//           slices, start/done handshake and ALU flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_cla_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             grp_prop,
  output logic             grp_gene
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("serial_cla_addsub: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  op_a, op_b, sum_sh, final_sum;
  logic [IDXW-1:0]   idx;
  logic              cin, p_acc, g_acc, last;

  logic [3:0] na, nb, np, ng, nc, nsum;
  logic       nprop, ngene, ncout;

  // Lookahead slice on the nibble currently selected by idx
  always_comb begin
    na    = op_a[idx*4 +: 4];
    nb    = op_b[idx*4 +: 4];
    np    = na ^ nb;
    ng    = na & nb;
    nc[0] = cin;
    nc[1] = ng[0] | (np[0] & cin);
    nc[2] = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & cin);
    nc[3] = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0])
          | (np[2] & np[1] & np[0] & cin);
    nsum  = np ^ nc;
    nprop = &np;
    ngene = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1])
          | (np[3] & np[2] & np[1] & ng[0]);
    ncout = ngene | (nprop & cin);
  end

  // The final nibble is not yet in the shadow register on the completion edge
  always_comb begin
    final_sum                = sum_sh;
    final_sum[WIDTH-1 -: 4]  = nsum;
  end

  assign last = (state == RUN) && (idx == LAST_IDX);

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      sum_sh   <= '0;
      idx      <= '0;
      cin      <= 1'b0;
      p_acc    <= 1'b0;
      g_acc    <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
      overflow <= 1'b0;
      grp_prop <= 1'b0;
      grp_gene <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        op_a  <= a;
        op_b  <= b ^ {WIDTH{op_sub}};
        cin   <= op_sub;
        idx   <= '0;
        g_acc <= 1'b0;
        p_acc <= 1'b1;
      end else if (state == RUN) begin
        sum_sh[idx*4 +: 4] <= nsum;
        cin   <= ncout;
        p_acc <= p_acc & nprop;
        g_acc <= ngene | (nprop & g_acc);
        idx   <= idx + 1'b1;
        if (last) begin
          result   <= final_sum;
          carry    <= ncout;
          overflow <= nc[3] ^ ncout;
          zero     <= ~|final_sum;
          sign     <= final_sum[WIDTH-1];
          grp_prop <= p_acc & nprop;
          grp_gene <= ngene | (nprop & g_acc);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_cla_addsub.sv
// ============================================================================
// Module  : tb_serial_cla_addsub
// Purpose : Directed-vector scoreboard bench for serial_cla_addsub.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_cla_addsub;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, op_sub = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic        busy, done, carry, zero, sign, overflow, grp_prop, grp_gene;

  serial_cla_addsub #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .sign(sign), .overflow(overflow), .grp_prop(grp_prop), .grp_gene(grp_gene)
  );

  always #5 clk = ~clk;

  // flags packed as {carry, zero, sign, overflow, grp_prop, grp_gene}
  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  flg;
  } exp_t;

  exp_t q[$];
  int   n_total = 0, n_pass = 0, n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("result", {32'd0, result}, {32'd0, e.res});
        chk("flags", {58'd0, carry, zero, sign, overflow, grp_prop, grp_gene},
            {58'd0, e.flg});
      end
    end
  end

  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input logic [31:0] er, input logic [5:0] ef, input bit push);
    a = va; b = vb; op_sub = vs; start = 1'b1;
    if (push) q.push_back('{res: er, flg: ef});
  endtask

  // Returns right after the done edge (+1) so a chained launch lands in the done cycle
  task automatic wait_done(input bit disturb);
    int          k;
    bit          steady;
    logic [31:0] res0;
    @(posedge clk); #1;
    start  = 1'b0;
    res0   = result;
    steady = (busy === 1'b1);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
      if (busy !== 1'b1 || result !== res0) steady = 1'b0;
      if (disturb && k == 1) begin start = 1'b1; a = 32'd9; b = 32'd9; op_sub = 1'b1; end
      if (disturb && k == 2) begin start = 1'b0; a = $urandom; b = $urandom; op_sub = 1'b0; end
    end
    chk("latency", 64'(k), 64'd8);
    chk("busy_steady", {63'd0, steady}, 64'd1);
  endtask

  logic [31:0] va [6] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0005,
                          32'h8000_0000, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
  logic [31:0] vb [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007,
                          32'h0000_0001, 32'h5555_5555, 32'hFFFF_FFFF};
  logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] vr [6] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE,
                          32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
  logic [5:0]  vf [6] = '{6'b110001, 6'b001100, 6'b001000,
                          6'b100101, 6'b001010, 6'b101001};

  initial begin
    int dn0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {50'd0, busy, done, carry, zero, sign, overflow, grp_prop, grp_gene,
                        6'd0}, 64'd0);
    chk("reset_result", {32'd0, result}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i], vs[i], vr[i], vf[i], 1'b1);
      wait_done(1'b0);
      @(posedge clk); #1;
    end

    // start while busy is ignored, operand changes have no effect
    dn0 = n_done;
    launch(32'd3, 32'd4, 1'b0, 32'd7, 6'b000000, 1'b1);
    wait_done(1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("single_done", 64'(n_done), 64'(dn0 + 1));

    // reset mid-operation aborts without a done pulse
    launch(32'h1234_5678, 32'h1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {22'd0, busy, done, result, carry, zero, sign, overflow,
                          grp_prop, grp_gene}, 64'd0);
    dn0 = n_done;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(n_done), 64'(dn0));

    // back-to-back: second start lands in the done cycle of the first
    launch(32'd2, 32'd2, 1'b0, 32'd4, 6'b000000, 1'b1);
    wait_done(1'b0);
    launch(32'd7, 32'd7, 1'b1, 32'd0, 6'b110010, 1'b1);
    wait_done(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
